// File: rtl/win_scanner.sv
// ---------------------------------------------------------------------------
// win_scanner
//
// Sequential line-win detector for an ROWS x COLS board of 2-bit cells.
// A snapshot of the board and the last move is taken on an accepted start.
// The scanner then walks outward from the last-placed piece, one probe cell
// per clock. It covers the horizontal, vertical, "\" and "/" directions in
// that order, and stops on the first direction that holds WIN_LEN pieces.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1. ready is high only while idle, so a start seen while busy is
// dropped, not queued. done is a single-cycle pulse. win/err/win_dir are
// valid from the done cycle and hold until the next accepted start. They
// read 0 during the check cycle that follows acceptance.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   start           : scan request
//   board           : cell (r,c) at board[(r*COLS+c)*2 +: 2]
//                     0 empty, 1/2 player, 3 illegal
//   last_row/col    : coordinates of the last move
//   player          : player to check (1 or 2)
//   ready, done     : idle indication, completion pulse
//   win, err        : result flags
//   win_dir         : 0 horiz, 1 vert, 2 "\", 3 "/"; 0 when no win
//   dbg_state       : current FSM state (IDLE=0, CHECK=1, SCAN=2, DONE=3)
// ---------------------------------------------------------------------------
module win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2*ROWS*COLS-1:0]     board,
  input  logic [$clog2(ROWS)-1:0]    last_row,
  input  logic [$clog2(COLS)-1:0]    last_col,
  input  logic [1:0]                 player,
  output logic                       ready,
  output logic                       done,
  output logic                       win,
  output logic                       err,
  output logic [1:0]                 win_dir,
  output logic [1:0]                 dbg_state
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  // Signed coordinate width; the two extra bits keep r +/- k from wrapping.
  localparam int SW = ((RW > CW) ? RW : CW) + 2;
  localparam int KW = $clog2(WIN_LEN + 1);

  localparam logic signed [SW-1:0] ROWS_S = SW'(ROWS);
  localparam logic signed [SW-1:0] COLS_S = SW'(COLS);
  localparam logic [KW-1:0]        K_ONE  = KW'(1);
  localparam logic [KW-1:0]        K_WIN  = KW'(WIN_LEN);
  localparam logic [KW-1:0]        K_LAST = KW'(WIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state,   w_state_n;
  logic [2*ROWS*COLS-1:0]  r_board,   w_board_n;
  logic [RW-1:0]           r_row,     w_row_n;
  logic [CW-1:0]           r_col,     w_col_n;
  logic [1:0]              r_player,  w_player_n;
  logic [1:0]              r_dir,     w_dir_n;
  logic                    r_side,    w_side_n;   // 0 = NEG, 1 = POS
  logic [KW-1:0]           r_k,       w_k_n;
  logic [KW-1:0]           r_count,   w_count_n;
  logic                    r_win,     w_win_n;
  logic                    r_err,     w_err_n;
  logic [1:0]              r_win_dir, w_win_dir_n;

  logic signed [SW-1:0]    w_row_s, w_col_s, w_k_s;
  logic signed [SW-1:0]    w_off_r, w_off_c, w_pr, w_pc;
  logic                    w_inb, w_match, w_bad, w_end_side;
  logic [1:0]              w_probe_cell, w_last_cell;
  logic [KW-1:0]           w_cnt_inc, w_k_inc;

  assign w_row_s = SW'(r_row);
  assign w_col_s = SW'(r_col);
  assign w_k_s   = SW'(r_k);

  // Offset k*(dr,dc) for the current direction; dr is 0 or 1, dc is -1..1.
  assign w_off_r = (r_dir == 2'd0) ? '0 : w_k_s;
  assign w_off_c = (r_dir == 2'd1) ? '0 :
                   (r_dir == 2'd3) ? -w_k_s : w_k_s;

  assign w_pr = r_side ? (w_row_s + w_off_r) : (w_row_s - w_off_r);
  assign w_pc = r_side ? (w_col_s + w_off_c) : (w_col_s - w_off_c);

  assign w_inb = !w_pr[SW-1] && !w_pc[SW-1] && (w_pr < ROWS_S) && (w_pc < COLS_S);

  // Cell lookups by coordinate compare. An out-of-range coordinate matches
  // no cell and reads as empty.
  always_comb begin
    w_probe_cell = 2'b00;
    w_last_cell  = 2'b00;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (w_pr == SW'(r) && w_pc == SW'(c))
          w_probe_cell = r_board[(r*COLS+c)*2 +: 2];
        if (w_row_s == SW'(r) && w_col_s == SW'(c))
          w_last_cell = r_board[(r*COLS+c)*2 +: 2];
      end
    end
  end

  assign w_match   = w_inb && (w_probe_cell == r_player);
  assign w_bad     = (w_row_s >= ROWS_S) || (w_col_s >= COLS_S) ||
                     ((r_player != 2'd1) && (r_player != 2'd2)) ||
                     (w_last_cell != r_player);
  assign w_cnt_inc = r_count + K_ONE;
  assign w_k_inc   = r_k + K_ONE;

  always_comb begin
    w_state_n   = r_state;
    w_board_n   = r_board;
    w_row_n     = r_row;
    w_col_n     = r_col;
    w_player_n  = r_player;
    w_dir_n     = r_dir;
    w_side_n    = r_side;
    w_k_n       = r_k;
    w_count_n   = r_count;
    w_win_n     = r_win;
    w_err_n     = r_err;
    w_win_dir_n = r_win_dir;
    w_end_side  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_board_n   = board;
          w_row_n     = last_row;
          w_col_n     = last_col;
          w_player_n  = player;
          w_win_n     = 1'b0;
          w_err_n     = 1'b0;
          w_win_dir_n = 2'd0;
          w_state_n   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_bad) begin
          w_err_n   = 1'b1;
          w_state_n = S_DONE;
        end else begin
          w_dir_n   = 2'd0;
          w_side_n  = 1'b0;
          w_k_n     = K_ONE;
          w_count_n = K_ONE;
          w_state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_match) begin
          w_count_n = w_cnt_inc;
          if (w_cnt_inc == K_WIN) begin
            w_win_n     = 1'b1;
            w_win_dir_n = r_dir;
            w_state_n   = S_DONE;
          end else if (w_k_inc > K_LAST) begin
            w_end_side = 1'b1;
          end else begin
            w_k_n = w_k_inc;
          end
        end else begin
          w_end_side = 1'b1;
        end
        // The count carries from the NEG side into the POS side of the same
        // line. It restarts only when the direction changes.
        if (w_end_side) begin
          w_k_n = K_ONE;
          if (!r_side) begin
            w_side_n = 1'b1;
          end else begin
            w_side_n  = 1'b0;
            w_count_n = K_ONE;
            w_dir_n   = r_dir + 2'd1;
            if (r_dir == 2'd3) w_state_n = S_DONE;
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_board   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_player  <= '0;
      r_dir     <= '0;
      r_side    <= 1'b0;
      r_k       <= '0;
      r_count   <= '0;
      r_win     <= 1'b0;
      r_err     <= 1'b0;
      r_win_dir <= '0;
    end else begin
      r_state   <= w_state_n;
      r_board   <= w_board_n;
      r_row     <= w_row_n;
      r_col     <= w_col_n;
      r_player  <= w_player_n;
      r_dir     <= w_dir_n;
      r_side    <= w_side_n;
      r_k       <= w_k_n;
      r_count   <= w_count_n;
      r_win     <= w_win_n;
      r_err     <= w_err_n;
      r_win_dir <= w_win_dir_n;
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);
  assign win       = r_win;
  assign err       = r_err;
  assign win_dir   = r_win_dir;
  assign dbg_state = r_state;

endmodule
